// File: rtl/mdu_ctrl_if.sv
// Handshake/bus bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side is master and the MDU side is slave.
interface mdu_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        op_i;
    logic              signed_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic              flush_i;
    logic              stallreq_for_ex;
    logic              busy_o;
    logic              result_valid_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output op_i, signed_i, src1_i, src2_i, flush_i,
        input  stallreq_for_ex, busy_o, result_valid_o, hi_o, lo_o
    );

    modport slave (
        input  op_i, signed_i, src1_i, src2_i, flush_i,
        output stallreq_for_ex, busy_o, result_valid_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one step per cycle, with sign correction applied as the result is registered into hi/lo.
module mdu_ctrl #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [2*DATA_W-1:0] acc_r, acc_step_s, prod_s;
    logic [DATA_W-1:0]   opnd_r, hi_r, lo_r, hi_fin_s, lo_fin_s, quot_s, rem_s;
    logic [5:0]          cnt_r;
    logic                neg_lo_r, neg_hi_r, div0_r, result_valid_r;
    logic                start_mul_s, start_div_s, last_s, stall_s, busy_s, div_ge_s;
    logic [DATA_W:0]     mul_sum_s, div_rem_s, div_diff_s;

    function automatic logic [DATA_W-1:0] mag_f(input logic [DATA_W-1:0] v, input logic sgn);
        if (sgn && v[DATA_W-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    assign start_mul_s = (state_r == ST_IDLE) && (bus.op_i == 2'b01) && !bus.flush_i;
    assign start_div_s = (state_r == ST_IDLE) && (bus.op_i == 2'b10) && !bus.flush_i;
    assign last_s      = (cnt_r == 6'(ITER - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; DONE never accepts a new op so it always falls back to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_mul_s) begin
                    state_nxt_s = ST_MUL;
                end else if (start_div_s) begin
                    state_nxt_s = ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Stall/busy decode; the IDLE stall is suppressed while reset is held
    always_comb begin
        stall_s = 1'b0;
        busy_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s = (start_mul_s || start_div_s) && !rst;
                busy_s  = 1'b0;
            end
            ST_MUL, ST_DIV: begin
                stall_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_DONE: begin
                stall_s = 1'b0;
                busy_s  = 1'b0;
            end
            default: begin
                stall_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // One iteration step: the multiply shifts right adding the multiplicand on a set LSB;
    // the divide shifts left and keeps the trial subtraction when it does not borrow
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + {1'b0, opnd_r};
        div_rem_s  = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
        div_diff_s = div_rem_s - {1'b0, opnd_r};
        div_ge_s   = !div_diff_s[DATA_W];
        acc_step_s = acc_r;
        if (state_r == ST_MUL) begin
            if (acc_r[0]) begin
                acc_step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
            end else begin
                acc_step_s = {1'b0, acc_r[2*DATA_W-1:1]};
            end
        end else if (state_r == ST_DIV) begin
            if (div_ge_s) begin
                acc_step_s = {div_diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
            end else begin
                acc_step_s = {div_rem_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_step_s = acc_r;
        end
    end

    // Sign correction of the final step; divide by zero forces an all-ones quotient
    always_comb begin
        prod_s = neg_lo_r ? -acc_step_s : acc_step_s;
        quot_s = acc_step_s[DATA_W-1:0];
        rem_s  = acc_step_s[2*DATA_W-1:DATA_W];
        if (state_r == ST_MUL) begin
            hi_fin_s = prod_s[2*DATA_W-1:DATA_W];
            lo_fin_s = prod_s[DATA_W-1:0];
        end else begin
            hi_fin_s = neg_hi_r ? -rem_s : rem_s;
            lo_fin_s = div0_r ? {DATA_W{1'b1}} : (neg_lo_r ? -quot_s : quot_s);
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r          <= {(2*DATA_W){1'b0}};
            opnd_r         <= {DATA_W{1'b0}};
            cnt_r          <= 6'd0;
            neg_lo_r       <= 1'b0;
            neg_hi_r       <= 1'b0;
            div0_r         <= 1'b0;
            hi_r           <= {DATA_W{1'b0}};
            lo_r           <= {DATA_W{1'b0}};
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_mul_s) begin
                        acc_r    <= {{DATA_W{1'b0}}, mag_f(bus.src2_i, bus.signed_i)};
                        opnd_r   <= mag_f(bus.src1_i, bus.signed_i);
                        neg_lo_r <= bus.signed_i && (bus.src1_i[DATA_W-1] ^ bus.src2_i[DATA_W-1]);
                        neg_hi_r <= 1'b0;
                        div0_r   <= 1'b0;
                        cnt_r    <= 6'd0;
                    end else if (start_div_s) begin
                        acc_r    <= {{DATA_W{1'b0}}, mag_f(bus.src1_i, bus.signed_i)};
                        opnd_r   <= mag_f(bus.src2_i, bus.signed_i);
                        neg_lo_r <= bus.signed_i && (bus.src1_i[DATA_W-1] ^ bus.src2_i[DATA_W-1]);
                        neg_hi_r <= bus.signed_i && bus.src1_i[DATA_W-1];
                        div0_r   <= (bus.src2_i == {DATA_W{1'b0}});
                        cnt_r    <= 6'd0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (last_s && !bus.flush_i) begin
                        hi_r           <= hi_fin_s;
                        lo_r           <= lo_fin_s;
                        result_valid_r <= 1'b1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.stallreq_for_ex = stall_s;
    assign bus.busy_o          = busy_s;
    assign bus.result_valid_o  = result_valid_r;
    assign bus.hi_o            = hi_r;
    assign bus.lo_o            = lo_r;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: vector table through a latency-tagged scoreboard, plus hand-written
// flush, reset and back-to-back sequences.
module tb_mdu_ctrl;
    localparam int W   = 32;
    localparam int LAT = 33;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_ctrl_if #(.DATA_W(W)) bus ();
    mdu_ctrl #(.DATA_W(W), .ITER(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]   op;
        logic         sgn;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi, lo;
        int           cyc;
    } exp_t;

    vec_t         vecs[16];
    exp_t         sb_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent reference using native wide arithmetic
    function automatic void model(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [63:0] p;
        longint      sa, sb, q, r;
        if (op == 2'b01) begin
            if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else     p = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Advance to the next falling edge and settle any result pulse against the scoreboard
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.result_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 64'(bus.result_valid_o), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("hi", 64'(bus.hi_o), 64'(e.hi));
                chk("lo", 64'(bus.lo_o), 64'(e.lo));
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("done_stall", 64'(bus.stallreq_for_ex), 64'd0);
                chk("done_busy", 64'(bus.busy_o), 64'd0);
                last_hi = e.hi;
                last_lo = e.lo;
            end
        end else if (sb_q.size() > 0 && cyc >= sb_q[0].cyc) begin
            chk("missing_valid", 64'(bus.result_valid_o), 64'd1);
            void'(sb_q.pop_front());
        end else if (sb_q.size() > 0 && cyc == sb_q[0].cyc - 1) begin
            chk("last_iter_busy", 64'(bus.busy_o), 64'd1);
            chk("last_iter_stall", 64'(bus.stallreq_for_ex), 64'd1);
        end
    endtask

    task automatic drive_start(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                               input bit push);
        exp_t e;
        bus.op_i     = op;
        bus.signed_i = sgn;
        bus.src1_i   = a;
        bus.src2_i   = b;
        bus.flush_i  = 1'b0;
        if (push) begin
            e.hi  = hi;
            e.lo  = lo;
            e.cyc = cyc + LAT;
            sb_q.push_back(e);
        end
        #1;
        chk("start_stall", 64'(bus.stallreq_for_ex), 64'd1);
    endtask

    // Run until the scoreboard empties; optionally scramble inputs while the unit iterates
    task automatic drain(input bit scramble);
        for (int i = 0; i < 120 && sb_q.size() > 0; i++) begin
            tick();
            if (sb_q.size() == 0) begin
                bus.op_i = 2'b00;
            end else if (scramble && cyc < sb_q[0].cyc - 1) begin
                bus.op_i     = 2'($urandom);
                bus.signed_i = 1'($urandom);
                bus.src1_i   = $urandom;
                bus.src2_i   = $urandom;
            end
        end
        if (sb_q.size() > 0) begin
            chk("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        logic [W-1:0] h, l;
        int           c0;
        exp_t         e2;

        vecs[0] = '{2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b01, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'b01, 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB};
        vecs[3] = '{2'b10, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{2'b10, 1'b0, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        vecs[5] = '{2'b10, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[6] = '{2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[7] = '{2'b10, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[8] = '{2'b10, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        for (int i = 10; i < 16; i++) begin
            vecs[i].op  = (i % 2 == 0) ? 2'b01 : 2'b10;
            vecs[i].sgn = 1'($urandom);
            vecs[i].a   = $urandom;
            vecs[i].b   = (i > 13) ? 32'($urandom_range(1, 1000)) : $urandom;
            model(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, h, l);
            vecs[i].hi  = h;
            vecs[i].lo  = l;
        end

        // Reset state with a request already on the bus
        rst = 1'b1;
        bus.op_i = 2'b01; bus.signed_i = 1'b0; bus.flush_i = 1'b0;
        bus.src1_i = 32'd9; bus.src2_i = 32'd9;
        tick(); tick();
        #1;
        chk("rst_hi", 64'(bus.hi_o), 64'd0);
        chk("rst_lo", 64'(bus.lo_o), 64'd0);
        chk("rst_valid", 64'(bus.result_valid_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_stall", 64'(bus.stallreq_for_ex), 64'd0);
        tick();
        rst = 1'b0;
        bus.op_i = 2'b00;

        for (int i = 0; i < 16; i++) begin
            tick();
            drive_start(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
            drain(1'b1);
        end

        // Flush at iteration 10: no pulse, hi/lo keep the last result
        tick();
        drive_start(2'b10, 1'b0, 32'd100, 32'd7, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.op_i = 2'b00;
        end
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("flush_busy", 64'(bus.busy_o), 64'd0);
        chk("flush_hi", 64'(bus.hi_o), 64'(last_hi));
        chk("flush_lo", 64'(bus.lo_o), 64'(last_lo));
        repeat (40) tick();

        // Flush in IDLE suppresses a start
        bus.op_i = 2'b01; bus.flush_i = 1'b1;
        #1;
        chk("idle_flush_stall", 64'(bus.stallreq_for_ex), 64'd0);
        tick();
        chk("idle_flush_busy", 64'(bus.busy_o), 64'd0);
        bus.op_i = 2'b00; bus.flush_i = 1'b0;

        // Asynchronous reset mid-divide, then a start in the first IDLE cycle after release
        tick();
        drive_start(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h5555_5555, 1'b1);
        repeat (5) begin
            tick();
            bus.op_i = 2'b00;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_hi", 64'(bus.hi_o), 64'd0);
        chk("arst_lo", 64'(bus.lo_o), 64'd0);
        chk("arst_valid", 64'(bus.result_valid_o), 64'd0);
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        chk("arst_stall", 64'(bus.stallreq_for_ex), 64'd0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        model(2'b01, 1'b0, 32'd12345, 32'd678, h, l);
        drive_start(2'b01, 1'b0, 32'd12345, 32'd678, h, l, 1'b1);
        drain(1'b1);

        // Back-to-back: multiply, then a divide held on op_i starts in the IDLE after DONE
        tick();
        c0 = cyc;
        drive_start(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        e2.hi  = 32'd2;
        e2.lo  = 32'd14;
        e2.cyc = c0 + 2 * LAT + 1;
        sb_q.push_back(e2);
        tick();
        bus.op_i = 2'b10; bus.signed_i = 1'b0;
        bus.src1_i = 32'd100; bus.src2_i = 32'd7;
        drain(1'b0);
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, operand and hi/lo width.
REQ-002 Parameter ITER, default 32, iteration cycles per operation; SHALL equal DATA_W.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 op_i  input  2  EX-stage request: 00 none, 01 multiply, 10 divide, 11 treated as none.
REQ-007 signed_i  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
REQ-008 src1_i  input  DATA_W  multiplicand / dividend.
REQ-009 src2_i  input  DATA_W  multiplier / divisor.
REQ-010 flush_i  input  1  pipeline flush; aborts the current operation.
REQ-011 stallreq_for_ex  output  1  stall request to the pipeline stall controller.
REQ-012 busy_o  output  1  high while in MUL or DIV state.
REQ-013 result_valid_o  output  1  one-cycle pulse when hi/lo are updated.
REQ-014 hi_o  output  DATA_W  product high half / remainder.
REQ-015 lo_o  output  DATA_W  product low half / quotient.

Function
REQ-016 FSM states: IDLE, MUL, DIV, DONE; one shared 2*DATA_W accumulator, DATA_W operand register, 6-bit iteration counter.
REQ-017 IDLE with op_i=01/10 at cycle T: latch operand magnitudes (absolute values if signed_i=1) and result signs; clear counter; go to MUL/DIV.
REQ-018 MUL: one shift-add step per cycle, LSB first; DIV: one restoring shift-subtract step per cycle, MSB first.
REQ-019 After ITER iteration cycles (T+1..T+ITER), go to DONE; DONE lasts exactly one cycle (T+ITER+1), then returns to IDLE.
REQ-020 stallreq_for_ex SHALL be high when (IDLE and op_i is 01/10 and flush_i=0) or state is MUL/DIV; low in DONE, so the instruction leaves EX at the end of DONE.
REQ-021 DONE SHALL NOT accept a new op; the next operation can start no earlier than the following IDLE cycle.
REQ-022 On entry to DONE, hi_o/lo_o SHALL register the sign-corrected result and result_valid_o SHALL be 1 for that cycle only; hi_o/lo_o hold until the next completion.
REQ-023 Signed multiply: negate the 2*DATA_W product when operand signs differ.
REQ-024 Signed divide: quotient negated when signs differ; remainder takes the dividend's sign.
REQ-025 Divide by zero: full ITER cycles; lo_o = all ones, hi_o = src1_i as latched (raw, unsigned bits).
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo_o=0x80000000, hi_o=0 (wraps, no trap).
REQ-027 flush_i=1 in any state SHALL return to IDLE next cycle with no result_valid_o pulse and hi_o/lo_o unchanged; flush_i in IDLE SHALL suppress a start.
REQ-028 op_i/src*_i changes during MUL/DIV SHALL be ignored.

Reset
REQ-029 While rst=1: state IDLE, counter 0, accumulator 0, hi_o=0, lo_o=0, result_valid_o=0, busy_o=0, stallreq_for_ex=0.
REQ-030 Reset mid-operation SHALL abandon the operation with no result pulse; first start is accepted in the first IDLE cycle after rst falls.

Verification
REQ-031 Unsigned mul 0xFFFFFFFF*0xFFFFFFFF at T -> stallreq high T..T+32, result_valid at T+33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 Signed mul -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; unsigned mul of the same bits -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-033 Signed div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned 7/2 -> lo=3, hi=1.
REQ-034 Divide 5/0 -> lo=0xFFFFFFFF, hi=0x00000005 after 33 cycles; signed 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-035 flush_i at iteration 10 -> IDLE next cycle, no result_valid, hi/lo keep prior values; rst asserted mid-DIV -> all outputs 0 immediately (asynchronous).
REQ-036 Back-to-back mul then div held on op_i -> second start in the IDLE cycle after DONE, exactly one result pulse each.
